// File: rtl/jtag_reg_access_if.sv
// ============================================================================
// Module      : jtag_reg_access_if
// Description : Debug request/response bus plus core halt and register-file
//               debug port bundle for jtag_reg_access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface jtag_reg_access_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [4:0]  req_addr_i;
    logic [31:0] req_data_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic        halt_req_o;
    logic        halt_ack_i;
    logic        jtag_we_o;
    logic [4:0]  jtag_addr_o;
    logic [31:0] jtag_data_o;
    logic [31:0] jtag_data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_data_i,
        input  resp_ready_i, halt_ack_i, jtag_data_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
        output halt_req_o, jtag_we_o, jtag_addr_o, jtag_data_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_data_i,
        output resp_ready_i, halt_ack_i, jtag_data_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
        input  halt_req_o, jtag_we_o, jtag_addr_o, jtag_data_o
    );
endinterface

`default_nettype wire

// File: rtl/jtag_reg_access.sv
// ============================================================================
// Module      : jtag_reg_access
// Description : Debug GPR read/write engine; halts the core, performs one
//               register-file access and returns a response. Define
//               JTAG_REG_HALT_EN to enable the halt handshake and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_reg_access #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic          clk,
    input  wire logic          rst,
    jtag_reg_access_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HALT_WAIT = 2'd1,
        ACCESS    = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        jtag_we_q, jtag_we_d;
    logic [4:0]  jtag_addr_q, jtag_addr_d;
    logic [31:0] jtag_data_q, jtag_data_d;
    logic        w_accept;

`ifdef JTAG_REG_HALT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             halt_req_q, halt_req_d;
    logic             resp_err_q, resp_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lat_we_q, lat_we_d;
    logic [4:0]       lat_addr_q, lat_addr_d;
    logic [31:0]      lat_data_q, lat_data_d;
`else
    logic w_unused_halt_ack;
    assign w_unused_halt_ack = bus.halt_ack_i;
`endif

    assign w_accept = bus.req_valid_i && req_ready_q;

    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        jtag_we_d    = 1'b0;
        jtag_addr_d  = jtag_addr_q;
        jtag_data_d  = jtag_data_q;
`ifdef JTAG_REG_HALT_EN
        halt_req_d   = halt_req_q;
        resp_err_d   = resp_err_q;
        cnt_d        = cnt_q;
        lat_we_d     = lat_we_q;
        lat_addr_d   = lat_addr_q;
        lat_data_d   = lat_data_q;
`endif

        case (state_q)
            IDLE: begin
                if (w_accept) begin
`ifdef JTAG_REG_HALT_EN
                    state_d    = HALT_WAIT;
                    halt_req_d = 1'b1;
                    cnt_d      = '0;
                    lat_we_d   = bus.req_we_i;
                    lat_addr_d = bus.req_addr_i;
                    lat_data_d = bus.req_data_i;
`else
                    state_d     = ACCESS;
                    jtag_we_d   = bus.req_we_i;
                    jtag_addr_d = bus.req_addr_i;
                    if (bus.req_we_i) begin
                        jtag_data_d = bus.req_data_i;
                    end
`endif
                end
            end

            HALT_WAIT: begin
`ifdef JTAG_REG_HALT_EN
                if (bus.halt_ack_i) begin
                    state_d     = ACCESS;
                    jtag_we_d   = lat_we_q;
                    jtag_addr_d = lat_addr_q;
                    if (lat_we_q) begin
                        jtag_data_d = lat_data_q;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Core never stalled: answer with an error, skip the access.
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                state_d = IDLE;
`endif
            end

            ACCESS: begin
                // jtag_we_q is high here exactly when the request is a write.
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_data_d  = jtag_we_q ? 32'd0 : bus.jtag_data_i;
`ifdef JTAG_REG_HALT_EN
                resp_err_d   = 1'b0;
`endif
            end

            RESP: begin
                if (bus.resp_ready_i) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_data_d  = '0;
`ifdef JTAG_REG_HALT_EN
                    halt_req_d   = 1'b0;
                    resp_err_d   = 1'b0;
`endif
                end
            end

            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            jtag_we_q    <= 1'b0;
            jtag_addr_q  <= '0;
            jtag_data_q  <= '0;
`ifdef JTAG_REG_HALT_EN
            halt_req_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            cnt_q        <= '0;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_data_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            jtag_we_q    <= jtag_we_d;
            jtag_addr_q  <= jtag_addr_d;
            jtag_data_q  <= jtag_data_d;
`ifdef JTAG_REG_HALT_EN
            halt_req_q   <= halt_req_d;
            resp_err_q   <= resp_err_d;
            cnt_q        <= cnt_d;
            lat_we_q     <= lat_we_d;
            lat_addr_q   <= lat_addr_d;
            lat_data_q   <= lat_data_d;
`endif
        end
    end

    assign bus.req_ready_o  = req_ready_q;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_data_o  = resp_data_q;
    assign bus.jtag_we_o    = jtag_we_q;
    assign bus.jtag_addr_o  = jtag_addr_q;
    assign bus.jtag_data_o  = jtag_data_q;
`ifdef JTAG_REG_HALT_EN
    assign bus.halt_req_o   = halt_req_q;
    assign bus.resp_err_o   = resp_err_q;
`else
    assign bus.halt_req_o   = 1'b0;
    assign bus.resp_err_o   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/jtag_reg_access.md
JTAG_REG_ACCESS -- requirements
Module: jtag_reg_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: maximum cycles spent waiting for halt_ack_i before an error response.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous reset, active-low.
REQ-004 SHALL have port req_valid_i, input, 1 bit: debug request valid.
REQ-005 SHALL have port req_ready_o, output, 1 bit: request accepted when both this and req_valid_i are high.
REQ-006 SHALL have port req_we_i, input, 1 bit: 1 = GPR write, 0 = GPR read.
REQ-007 SHALL have port req_addr_i, input, 5 bits: GPR index.
REQ-008 SHALL have port req_data_i, input, 32 bits: write data.
REQ-009 SHALL have port resp_valid_o, output, 1 bit: response valid.
REQ-010 SHALL have port resp_ready_i, input, 1 bit: response consumed when both this and resp_valid_o are high.
REQ-011 SHALL have port resp_data_o, output, 32 bits: read data; 0 for writes and errors.
REQ-012 SHALL have port resp_err_o, output, 1 bit: halt timeout, access not performed.
REQ-013 SHALL have port halt_req_o, output, 1 bit: request to stall the core pipeline.
REQ-014 SHALL have port halt_ack_i, input, 1 bit: core confirms it is stalled and issues no GPR writes.
REQ-015 SHALL have port jtag_we_o, output, 1 bit: register-file debug write enable.
REQ-016 SHALL have port jtag_addr_o, output, 5 bits: register-file debug address.
REQ-017 SHALL have port jtag_data_o, output, 32 bits: register-file debug write data.
REQ-018 SHALL have port jtag_data_i, input, 32 bits: combinational register-file debug read data; reads 0 for x0.

Function
REQ-019 SHALL implement the states IDLE, HALT_WAIT, ACCESS and RESP.
REQ-020 req_ready_o SHALL be 1 only in IDLE; on acceptance, latch we/addr/data and move to HALT_WAIT.
REQ-021 halt_req_o SHALL be 1 in HALT_WAIT, ACCESS and RESP, and 0 in IDLE.
REQ-022 In HALT_WAIT: halt_ack_i sampled 1 -> ACCESS; otherwise increment the wait counter; counter reaching TIMEOUT_CYCLES-1 -> RESP with resp_err_o=1, resp_data_o=0, and no register-file access.
REQ-023 ACCESS SHALL last exactly one cycle, with jtag_addr_o = latched address.
REQ-024 In ACCESS, a write SHALL assert jtag_we_o with jtag_data_o = latched data; a read SHALL capture jtag_data_i into resp_data_o.
REQ-025 jtag_we_o SHALL be 1 only in ACCESS for a write request.
REQ-026 jtag_addr_o and jtag_data_o SHALL hold their last value outside ACCESS.
REQ-027 A write to x0 SHALL complete normally with resp_err_o=0; the register file discards the data.
REQ-028 In RESP: resp_valid_o=1 with data/err stable until resp_ready_i; on that handshake -> IDLE, and halt_req_o drops in the same transition.
REQ-029 Latency with halt_ack_i already high: accept at cycle 0, ACCESS at cycle 2, resp_valid_o at cycle 3.
REQ-030 A new request SHALL not be accepted in the cycle the response completes; the earliest next acceptance is the following IDLE cycle.
REQ-031 A drop of halt_ack_i during ACCESS or RESP SHALL be ignored; the access proceeds.

Reset
REQ-032 With rst=0 at a clock edge, the block SHALL go to IDLE and clear the wait counter.
REQ-033 Reset values SHALL be: req_ready_o=0 during reset, 1 after release; resp_valid_o, resp_err_o, halt_req_o and jtag_we_o = 0; resp_data_o, jtag_addr_o and jtag_data_o = 0.
REQ-034 Reset mid-transaction SHALL abandon the request and SHALL not produce a response or a jtag_we_o pulse.

Configuration
REQ-035 Macro JTAG_REG_HALT_EN, when defined, SHALL enable the HALT_WAIT behaviour as specified in REQ-021/022.
REQ-036 Without JTAG_REG_HALT_EN, acceptance SHALL go directly to ACCESS, halt_req_o SHALL be tied 0, halt_ack_i SHALL be ignored, resp_err_o SHALL be tied 0, and the response SHALL arrive at cycle 2.

Verification
REQ-037 With halt_ack tied 1, write addr 5, data 0xDEADBEEF -> one jtag_we_o pulse, addr 5, at cycle 2; resp_valid at cycle 3, err=0, data=0.
REQ-038 With jtag_data_i=0x12345678, read addr 5 -> resp_data_o=0x12345678, err=0.
REQ-039 With TIMEOUT_CYCLES=4 and halt_ack held 0 -> resp_err_o=1 after 4 HALT_WAIT cycles, no jtag_we_o pulse, halt_req_o falls after the handshake.
REQ-040 resp_ready_i held 0 for 10 cycles -> resp_valid_o, data and halt_req_o stay stable; req_ready_o stays 0.
REQ-041 rst=0 asserted during HALT_WAIT of a write -> no jtag_we_o pulse, all outputs reach reset values at the next edge.
REQ-042 Write x0 = 0xFFFFFFFF, then read x0 -> both complete with err=0; the read returns 0.
